// File: rtl/adc_spi_rx.sv
// adc_spi_rx: periodic SPI read of a 12-bit ADC.
// A sample timer launches one 16-bit frame per SAMPLE_DIV clocks. Each frame is
// 4 leading zero bits followed by 12 data bits, MSB first. The 12-bit result is
// presented on data_out together with a one-clock ready pulse.
module adc_spi_rx #(
    parameter int SCLK_DIV   = 4,
    parameter int SAMPLE_DIV = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        miso,
    output logic        sclk,
    output logic        cs_n,
    output logic [11:0] data_out,
    output logic        ready,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun
);

    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(SCLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        SHIFT    = 2'd2,
        CS_HOLD  = 2'd3
    } state_t;

    // A frame is malformed when any of its four leading bits is set.
    function automatic logic lead_bits_set(input logic [15:0] frame);
        lead_bits_set = (frame[15:12] != 4'b0000);
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [TW-1:0]   timer_r;
    logic            en_d_r;
    logic            tick_s;
    logic [CW-1:0]   div_cnt_r;
    logic [CW-1:0]   div_cnt_s;
    logic [3:0]      bit_cnt_r;
    logic [3:0]      bit_cnt_s;
    logic            phase_r;
    logic            phase_s;
    logic [15:0]     shift_r;
    logic [15:0]     shift_s;
    logic            sclk_s;
    logic            cs_n_s;
    logic [11:0]     data_s;
    logic            ready_s;
    logic            busy_s;
    logic            ferr_s;
    logic            ovr_s;

    // Sample timer: stays at zero on the first enabled cycle, then counts modulo SAMPLE_DIV.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= '0;
            en_d_r  <= 1'b0;
        end else if (!en) begin
            timer_r <= '0;
            en_d_r  <= 1'b0;
        end else begin
            en_d_r <= 1'b1;
            if (!en_d_r) begin
                timer_r <= '0;
            end else if (timer_r == TIMER_LAST) begin
                timer_r <= '0;
            end else begin
                timer_r <= timer_r + TW'(1);
            end
        end
    end

    assign tick_s = en && en_d_r && (timer_r == TIMER_LAST);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_s   = state_r;
        div_cnt_s = div_cnt_r;
        bit_cnt_s = bit_cnt_r;
        phase_s   = phase_r;
        shift_s   = shift_r;
        sclk_s    = sclk;
        cs_n_s    = cs_n;
        data_s    = data_out;
        ready_s   = 1'b0;
        ferr_s    = frame_err;
        ovr_s     = overrun | (tick_s && (state_r != IDLE));

        if (!en) begin
            // Disable aborts any frame in flight; results and flags are kept.
            state_s   = IDLE;
            div_cnt_s = '0;
            bit_cnt_s = 4'd0;
            phase_s   = 1'b0;
            sclk_s    = 1'b1;
            cs_n_s    = 1'b1;
            ovr_s     = overrun;
        end else begin
            case (state_r)
                IDLE: begin
                    sclk_s    = 1'b1;
                    cs_n_s    = 1'b1;
                    div_cnt_s = '0;
                    if (tick_s) begin
                        state_s = CS_SETUP;
                        cs_n_s  = 1'b0;
                        shift_s = 16'h0000;
                    end else begin
                        state_s = IDLE;
                    end
                end
                CS_SETUP: begin
                    if (div_cnt_r == DIV_LAST) begin
                        state_s   = SHIFT;
                        div_cnt_s = '0;
                        bit_cnt_s = 4'd0;
                        phase_s   = 1'b0;
                        sclk_s    = 1'b0;
                    end else begin
                        div_cnt_s = div_cnt_r + CW'(1);
                    end
                end
                SHIFT: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_s = '0;
                        if (!phase_r) begin
                            // Rising SCLK edge: the ADC bit has been stable for a full low phase.
                            phase_s = 1'b1;
                            sclk_s  = 1'b1;
                            shift_s = {shift_r[14:0], miso};
                        end else if (bit_cnt_r == 4'd15) begin
                            state_s = CS_HOLD;
                        end else begin
                            phase_s   = 1'b0;
                            sclk_s    = 1'b0;
                            bit_cnt_s = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        div_cnt_s = div_cnt_r + CW'(1);
                    end
                end
                CS_HOLD: begin
                    if (div_cnt_r == DIV_LAST) begin
                        state_s   = IDLE;
                        div_cnt_s = '0;
                        cs_n_s    = 1'b1;
                        ready_s   = 1'b1;
                        data_s    = shift_r[11:0];
                        ferr_s    = frame_err | lead_bits_set(shift_r);
                    end else begin
                        div_cnt_s = div_cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_s   = IDLE;
                    div_cnt_s = '0;
                    sclk_s    = 1'b1;
                    cs_n_s    = 1'b1;
                end
            endcase
        end

        busy_s = (state_s != IDLE);
    end

    // State and output registers; reset overrides enable and tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            div_cnt_r <= '0;
            bit_cnt_r <= 4'd0;
            phase_r   <= 1'b0;
            shift_r   <= 16'h0000;
            sclk      <= 1'b1;
            cs_n      <= 1'b1;
            data_out  <= 12'h000;
            ready     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_r   <= state_s;
            div_cnt_r <= div_cnt_s;
            bit_cnt_r <= bit_cnt_s;
            phase_r   <= phase_s;
            shift_r   <= shift_s;
            sclk      <= sclk_s;
            cs_n      <= cs_n_s;
            data_out  <= data_s;
            ready     <= ready_s;
            busy      <= busy_s;
            frame_err <= ferr_s;
            overrun   <= ovr_s;
        end
    end

endmodule
